// File: rtl/display_pkg.sv
// Shared encodings for the register display: FSM states, input lanes and the hex glyph table.
package display_pkg;

  typedef enum logic [1:0] {
    S_MANUAL = 2'd0,
    S_AUTO   = 2'd1,
    S_HOLD   = 2'd2
  } state_e;

  // Conditioned inputs share one lane width; single-bit inputs ride zero-extended.
  localparam int NUM_IN    = 3;
  localparam int IN_W      = 3;
  localparam int LANE_SW   = 0;
  localparam int LANE_AUTO = 1;
  localparam int LANE_HOLD = 2;

  // Active-high glyphs, bit order {g,f,e,d,c,b,a}; b and d are lowercase.
  localparam logic [6:0] HEX_GLYPH [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/hex_to_seven_seg.sv
// One hex nibble to an active-high seven-segment glyph; purely combinational.
module hex_to_seven_seg
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);
  assign glyph = HEX_GLYPH[nibble];
endmodule

// File: rtl/reg_display_scanner.sv
// Register-file viewer: shows one of r1..r8 as four hex digits, selected manually,
// by timed auto-scan, or frozen by a hold toggle.
module reg_display_scanner
  import display_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DWELL_CYCLES    = 50000000,
  parameter bit SEG_ACTIVE_LOW  = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   sw,
  input  logic         auto_en,
  input  logic         hold_btn,
  input  logic [127:0] regs_in,
  output logic [6:0]   seg0,
  output logic [6:0]   seg1,
  output logic [6:0]   seg2,
  output logic [6:0]   seg3,
  output logic [2:0]   sel_idx,
  output logic         holding
);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int DW_W = $clog2(DWELL_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL_CYCLES - 1);
  // Blank pattern and polarity mask coincide: all ones when segments are active-low.
  localparam logic [6:0] SEG_POL = {7{SEG_ACTIVE_LOW}};

  logic [NUM_IN-1:0][IN_W-1:0] raw, db;
  assign raw = {{(IN_W-1)'(0), hold_btn}, {(IN_W-1)'(0), auto_en}, sw};

  for (genvar i = 0; i < NUM_IN; i++) begin : g_db
    logic [IN_W-1:0] s1, s2, s_prev, val;
    logic [DB_W-1:0] cnt;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        s1     <= '0;
        s2     <= '0;
        s_prev <= '0;
        val    <= '0;
        cnt    <= '0;
      end else begin
        s1     <= raw[i];
        s2     <= s1;
        s_prev <= s2;
        if (s2 != s_prev)       cnt <= '0;
        else if (cnt == DB_LAST) val <= s2;
        else                     cnt <= cnt + DB_W'(1);
      end
    end
    assign db[i] = val;
  end

  logic [2:0] sw_db;
  logic       auto_db, hold_db, hold_q, hold_press;
  assign sw_db      = db[LANE_SW];
  assign auto_db    = |db[LANE_AUTO];
  assign hold_db    = |db[LANE_HOLD];
  assign hold_press = hold_db & ~hold_q;

  state_e          state, state_nx;
  logic [2:0]      sel_nx;
  logic [DW_W-1:0] dwell, dwell_nx;

  // hold_press outranks every other transition, including an auto-scan wrap.
  always_comb begin
    state_nx = state;
    sel_nx   = sel_idx;
    dwell_nx = dwell;
    if (hold_press) begin
      state_nx = (state == S_HOLD) ? (auto_db ? S_AUTO : S_MANUAL) : S_HOLD;
    end else begin
      case (state)
        S_MANUAL: begin
          if (auto_db) begin
            state_nx = S_AUTO;
            dwell_nx = '0;
          end else begin
            sel_nx = sw_db;
          end
        end
        S_AUTO: begin
          if (!auto_db) begin
            state_nx = S_MANUAL;
          end else if (dwell == DW_LAST) begin
            dwell_nx = '0;
            sel_nx   = sel_idx + 3'd1;
          end else begin
            dwell_nx = dwell + DW_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  logic [15:0]     shown;
  logic [3:0][6:0] glyph, seg_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_MANUAL;
      sel_idx <= '0;
      dwell   <= '0;
      hold_q  <= 1'b0;
      shown   <= '0;
      seg_q   <= {4{SEG_POL}};
    end else begin
      state   <= state_nx;
      sel_idx <= sel_nx;
      dwell   <= dwell_nx;
      hold_q  <= hold_db;
      // The first S_HOLD cycle keeps whatever the prior state loaded last.
      if (state != S_HOLD) shown <= regs_in[{sel_idx, 4'b0000} +: 16];
      seg_q   <= glyph ^ {4{SEG_POL}};
    end
  end

  hex_to_seven_seg u_hex [3:0] (
    .nibble(shown),
    .glyph (glyph)
  );

  assign seg0    = seg_q[0];
  assign seg1    = seg_q[1];
  assign seg2    = seg_q[2];
  assign seg3    = seg_q[3];
  assign holding = (state == S_HOLD);

endmodule
